// File: rtl/gray_to_bin_sweeper.sv
// gray_to_bin_sweeper: walks memory [START_ADDR..LAST_ADDR], reads each gray
// byte, decodes it bit-serially (MSB first) and writes the binary value back.
// Optional feature macro: CHECKSUM_EN adds an XOR checksum of written words.
module gray_to_bin_sweeper #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 6,
  parameter int START_ADDR = 0,
  parameter int LAST_ADDR  = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ren,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata
`ifdef CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0]     MSB_IDX = CW'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] A_FIRST = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] A_LAST  = ADDR_W'(LAST_ADDR);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CONV, S_WRITE, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] gray_r, bin_r, bin_nxt;
  logic [CW-1:0]     bit_cnt, cnt_up;
  logic              prev_bit, at_last, accept;

  assign at_last = (mem_addr == A_LAST);
  assign accept  = (state == S_IDLE) && start;

  // One decode step: bit i = bit i+1 of the result XOR gray bit i (MSB copies through)
  always_comb begin
    cnt_up   = bit_cnt + 1'b1;
    prev_bit = (bit_cnt == MSB_IDX) ? 1'b0 : bin_r[cnt_up];
    bin_nxt  = bin_r;
    bin_nxt[bit_cnt] = prev_bit ^ gray_r[bit_cnt];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and strobe decode; strobes depend only on the current state
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_READ;
      S_READ:  begin
        busy = 1'b1; mem_ren = 1'b1; state_nxt = S_CONV;
      end
      S_CONV:  begin
        busy = 1'b1;
        if (bit_cnt == '0) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        busy = 1'b1; mem_wen = 1'b1;
        state_nxt = at_last ? S_DONE : S_READ;
      end
      S_DONE:  begin
        busy = 1'b1; done = 1'b1; state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: address walk, gray capture, serial decode, write-data register
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= A_FIRST;
      mem_wdata <= '0;
      gray_r    <= '0;
      bin_r     <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE:  if (start) mem_addr <= A_FIRST;
        S_READ:  begin
          gray_r  <= mem_rdata;
          bin_r   <= '0;
          bit_cnt <= MSB_IDX;
        end
        S_CONV:  begin
          bin_r <= bin_nxt;
          if (bit_cnt == '0) mem_wdata <= bin_nxt;
          else               bit_cnt   <= bit_cnt - 1'b1;
        end
        // LAST_ADDR stops the walk, so the address never wraps
        S_WRITE: if (!at_last) mem_addr <= mem_addr + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CHECKSUM_EN
  // XOR of every word written this sweep; held after done until the next start
  always_ff @(posedge clk) begin
    if (rst || accept)          checksum <= '0;
    else if (state == S_WRITE)  checksum <= checksum ^ mem_wdata;
  end
`endif

endmodule

// File: tb/tb_gray_to_bin_sweeper.sv
// Bench for gray_to_bin_sweeper: a full-range instance and a single-word
// instance (START_ADDR = LAST_ADDR = 63), each with a model memory. Expected
// writes go into a queue when a sweep is launched; a monitor pops and checks
// them on every write strobe.
module tb_gray_to_bin_sweeper;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start1 = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  logic [7:0] mem0 [64];
  logic [7:0] mem1 [64];

  logic       busy0, done0, ren0, wen0, busy1, done1, ren1, wen1;
  logic [5:0] addr0, addr1;
  logic [7:0] wdata0, wdata1, rdata0, rdata1;
`ifdef CHECKSUM_EN
  logic [7:0] csum0, csum1;
`endif

  assign rdata0 = ren0 ? mem0[addr0] : 'z;
  assign rdata1 = ren1 ? mem1[addr1] : 'z;

  gray_to_bin_sweeper u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
    .mem_addr(addr0), .mem_ren(ren0), .mem_wen(wen0),
    .mem_rdata(rdata0), .mem_wdata(wdata0)
`ifdef CHECKSUM_EN
    , .checksum(csum0)
`endif
  );

  gray_to_bin_sweeper #(.START_ADDR(63), .LAST_ADDR(63)) u_one (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .mem_addr(addr1), .mem_ren(ren1), .mem_wen(wen1),
    .mem_rdata(rdata1), .mem_wdata(wdata1)
`ifdef CHECKSUM_EN
    , .checksum(csum1)
`endif
  );

  // Model memories commit on the falling edge
  always @(negedge clk) begin
    if (wen0) mem0[addr0] = wdata0;
    if (wen1) mem1[addr1] = wdata1;
  end

  typedef struct { logic [5:0] a; logic [7:0] d; } wr_t;
  wr_t q0[$];
  wr_t q1[$];
  int  ren1_cnt = 0, wen1_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] g(input int i);
    return 8'(i ^ (i >> 1));
  endfunction

  // Scoreboard monitor plus per-cycle protocol checks
  always @(negedge clk) begin
    wr_t e;
    chk("ren_wen_excl0", {31'd0, ren0 && wen0}, 0);
    chk("ren_wen_excl1", {31'd0, ren1 && wen1}, 0);
    chk("addr_range1", 32'(addr1), 63);
    if (ren1) ren1_cnt++;
    if (wen1) wen1_cnt++;
    if (wen0) begin
      if (q0.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_write0: addr %0d data %0h, none expected", addr0, wdata0);
      end else begin
        e = q0.pop_front();
        chk("wr_addr0", 32'(addr0), 32'(e.a));
        chk("wr_data0", 32'(wdata0), 32'(e.d));
      end
    end
    if (wen1) begin
      if (q1.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_write1: addr %0d data %0h, none expected", addr1, wdata1);
      end else begin
        e = q1.pop_front();
        chk("wr_addr1", 32'(addr1), 32'(e.a));
        chk("wr_data1", 32'(wdata1), 32'(e.d));
      end
    end
  end

  // Write data must hold from the start to the end of each WRITE cycle
  always begin
    logic [7:0] w0, w1;
    @(posedge clk);
    #1; w0 = wdata0; w1 = wdata1;
    #7;
    if (wen0) chk("wdata_stable0", 32'(wdata0), 32'(w0));
    if (wen1) chk("wdata_stable1", 32'(wdata1), 32'(w1));
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},  32'(busy0), 0);
    chk({tag, "_done"},  32'(done0), 0);
    chk({tag, "_ren"},   32'(ren0), 0);
    chk({tag, "_wen"},   32'(wen0), 0);
    chk({tag, "_addr"},  32'(addr0), 0);
    chk({tag, "_wdata"}, 32'(wdata0), 0);
  endtask

  // Launch a sweep on u_dut and follow it to done (or to a mid-sweep reset)
  task automatic run0(input string tag, input int rst_at, input bit repulse);
    int  c0;
    bit  fin = 1'b0, busy_ok = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; c0 = cyc;
    for (int k = 0; k < 2000 && !fin; k++) begin
      if (busy0 !== 1'b1) busy_ok = 1'b0;
      start = repulse && ((cyc - c0) == 3 || (cyc - c0) == 300);
      if (done0) begin
        fin = 1'b1;
        chk({tag, "_done_lat"}, 32'(cyc - c0), 640);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done0), 0);
        chk({tag, "_idle_busy"}, 32'(busy0), 0);
      end else if (rst_at > 0 && (cyc - c0) == rst_at) begin
        fin = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs({tag, "_abort"});
        rst = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!fin) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: no done within 2000 cycles, required one", tag);
    end
    chk({tag, "_busy_held"}, 32'(busy_ok), 1);
  endtask

  initial begin
    logic [7:0] gin [5];
    logic [7:0] bout [5];
    logic [7:0] xs;
    int c0;
    bit fin;
    gin  = '{8'h80, 8'hC0, 8'h03, 8'h00, 8'h01};
    bout = '{8'hFF, 8'h80, 8'h02, 8'h00, 8'h01};
    for (int i = 0; i < 64; i++) begin mem0[i] = g(i); mem1[i] = g(i); end

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    chk("reset_addr1", 32'(addr1), 63);
    rst = 1'b0;
    @(negedge clk);

    // Full sweep of gray(i)
    for (int i = 0; i < 64; i++) begin mem0[i] = g(i); q0.push_back('{6'(i), 8'(i)}); end
    run0("sweep", 0, 1'b0);
    for (int i = 0; i < 64; i++) chk($sformatf("sweep_mem%0d", i), 32'(mem0[i]), i);
`ifdef CHECKSUM_EN
    chk("sweep_csum", 32'(csum0), 0);
`endif

    // Single-word vectors placed at addresses 0..4
    xs = 8'h00;
    for (int i = 0; i < 64; i++) begin
      logic [7:0] d;
      d = (i < 5) ? bout[i] : 8'(i);
      mem0[i] = (i < 5) ? gin[i] : g(i);
      q0.push_back('{6'(i), d});
      xs ^= d;
    end
    run0("vec", 0, 1'b0);
    for (int i = 0; i < 5; i++) chk($sformatf("vec_mem%0d", i), 32'(mem0[i]), 32'(bout[i]));
`ifdef CHECKSUM_EN
    chk("vec_csum", 32'(csum0), 32'(xs));
`endif

    // Reset at cycle 205: word 20 is mid-decode and must stay gray
    for (int i = 0; i < 64; i++) mem0[i] = g(i);
    for (int i = 0; i < 20; i++) q0.push_back('{6'(i), 8'(i)});
    run0("rst", 205, 1'b0);
    chk("rst_q_empty", 32'(q0.size()), 0);
    for (int i = 0; i < 64; i++)
      chk($sformatf("rst_mem%0d", i), 32'(mem0[i]), (i < 20) ? i : 32'(g(i)));
    repeat (3) @(negedge clk);
    chk("rst_stays_idle", 32'(busy0), 0);

    // start re-pulsed at cycles 3 and 300: ignored
    for (int i = 0; i < 64; i++) begin mem0[i] = g(i); q0.push_back('{6'(i), 8'(i)}); end
    run0("restart", 0, 1'b1);
    chk("restart_q_empty", 32'(q0.size()), 0);
    for (int i = 0; i < 64; i++) chk($sformatf("restart_mem%0d", i), 32'(mem0[i]), i);

    // One-word instance at address 63
    mem1[63] = 8'hC0;
    q1.push_back('{6'd63, 8'h80});
    @(negedge clk);
    ren1_cnt = 0; wen1_cnt = 0;
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; c0 = cyc;
    fin = 1'b0;
    for (int k = 0; k < 100 && !fin; k++) begin
      if (done1) begin fin = 1'b1; chk("one_done_lat", 32'(cyc - c0), 10); end
      else @(negedge clk);
    end
    if (!fin) begin
      n_chk++; n_fail++;
      $display("FAIL one_timeout: no done within 100 cycles, required one");
    end
    repeat (3) @(negedge clk);
    chk("one_reads", 32'(ren1_cnt), 1);
    chk("one_writes", 32'(wen1_cnt), 1);
    chk("one_mem63", 32'(mem1[63]), 32'h80);
    chk("one_mem62", 32'(mem1[62]), 32'(g(62)));
    chk("one_q_empty", 32'(q1.size()), 0);
`ifdef CHECKSUM_EN
    chk("one_csum", 32'(csum1), 32'h80);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
